display_sequencer: RTL and testbench

DISPLAY_SEQUENCER -- requirements
Module: display_sequencer

---
 rtl/display_sequencer.sv | 164 ++++++++++++++++
 tb/tb_display_sequencer.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/display_sequencer.sv
// Clock display sequencer: set/adjust mode FSM driven by synchronized buttons, a seconds-tick
// prescaler with set-mode blink, and a frame FSM that shifts six digits out and latches them.
module display_sequencer #(
  parameter int TICK_DIV    = 1000,
  parameter int REFRESH_DIV = 100
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_set,
  input  logic       i_up,
  input  logic       i_down,
  input  logic       i_srbusy,
  output logic       o_srload,
  output logic [2:0] o_muxsel,
  output logic       o_latch,
  output logic       o_cnt_en,
  output logic       o_adj_min,
  output logic       o_adj_hr,
  output logic       o_adj_dir,
  output logic       o_blank
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST    = TW'(TICK_DIV - 1);
  localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_DIV - 1);

  typedef enum logic [1:0] {MODE_RUN, MODE_SET_HR, MODE_SET_MIN} mode_t;
  typedef enum logic [2:0] {FR_IDLE, FR_LOAD, FR_ARM, FR_WAIT, FR_LATCH} frame_t;

  logic [2:0]    set_sync, up_sync, down_sync;
  logic          set_rise, up_rise, down_rise;
  mode_t         mode;
  logic [TW-1:0] presc;
  logic          tick_wrap;
  logic          blink;
  logic [RW-1:0] refresh;
  logic          ref_wrap;
  logic          pending;
  frame_t        frame;
  logic [2:0]    digit;
  logic          frame_take, load_next, latch_next;
  logic          adj_req, adj_held, held_hr, held_dir;

  // Bit 2 is the previous synchronized value, so edges are seen on bits [2:1].
  assign set_rise  = set_sync[1]  & ~set_sync[2];
  assign up_rise   = up_sync[1]   & ~up_sync[2];
  assign down_rise = down_sync[1] & ~down_sync[2];

  assign tick_wrap  = (presc == TICK_LAST);
  assign ref_wrap   = (refresh == REFRESH_LAST);
  assign frame_take = (frame == FR_IDLE) && pending;
  assign load_next  = frame_take || ((frame == FR_WAIT) && !i_srbusy && (digit != 3'd5));
  assign latch_next = (frame == FR_WAIT) && !i_srbusy && (digit == 3'd5);
  assign adj_req    = (mode != MODE_RUN) && (up_rise ^ down_rise);

  assign o_muxsel = digit;
  assign o_blank  = blink && (((mode == MODE_SET_HR)  && (digit >= 3'd4)) ||
                              ((mode == MODE_SET_MIN) && ((digit == 3'd2) || (digit == 3'd3))));

  // Adjust strobes that would land on a load/latch cycle are held back by one cycle;
  // frame strobes are never back to back, so one cycle is always enough.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      set_sync  <= '0;
      up_sync   <= '0;
      down_sync <= '0;
      mode      <= MODE_RUN;
      presc     <= '0;
      blink     <= 1'b0;
      o_cnt_en  <= 1'b0;
      o_adj_hr  <= 1'b0;
      o_adj_min <= 1'b0;
      o_adj_dir <= 1'b0;
      adj_held  <= 1'b0;
      held_hr   <= 1'b0;
      held_dir  <= 1'b0;
    end else begin
      set_sync  <= {set_sync[1:0], i_set};
      up_sync   <= {up_sync[1:0], i_up};
      down_sync <= {down_sync[1:0], i_down};

      if (set_rise) begin
        case (mode)
          MODE_RUN:    mode <= MODE_SET_HR;
          MODE_SET_HR: mode <= MODE_SET_MIN;
          default:     mode <= MODE_RUN;
        endcase
      end

      if ((set_rise && (mode == MODE_SET_MIN)) || tick_wrap)
        presc <= '0;
      else
        presc <= presc + 1'b1;

      if (set_rise)
        blink <= 1'b0;
      else if (tick_wrap)
        blink <= ~blink;

      o_cnt_en  <= tick_wrap && (mode == MODE_RUN) && !set_rise;
      o_adj_hr  <= 1'b0;
      o_adj_min <= 1'b0;
      o_adj_dir <= 1'b0;

      if (adj_held) begin
        o_adj_hr  <= held_hr;
        o_adj_min <= ~held_hr;
        o_adj_dir <= held_dir;
        adj_held  <= 1'b0;
      end else if (adj_req) begin
        if (load_next || latch_next) begin
          adj_held <= 1'b1;
          held_hr  <= (mode == MODE_SET_HR);
          held_dir <= up_rise;
        end else begin
          o_adj_hr  <= (mode == MODE_SET_HR);
          o_adj_min <= (mode == MODE_SET_MIN);
          o_adj_dir <= up_rise;
        end
      end
    end
  end

  // Frame FSM runs regardless of mode; the pending flag queues at most one frame start.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      refresh  <= '0;
      pending  <= 1'b0;
      frame    <= FR_IDLE;
      digit    <= 3'd0;
      o_srload <= 1'b0;
      o_latch  <= 1'b0;
    end else begin
      refresh  <= ref_wrap ? '0 : refresh + 1'b1;
      pending  <= (pending && !frame_take) || (ref_wrap && !pending);
      o_srload <= load_next;
      o_latch  <= latch_next;
      case (frame)
        FR_IDLE: begin
          if (pending) begin
            digit <= 3'd0;
            frame <= FR_LOAD;
          end
        end
        FR_LOAD:  frame <= FR_ARM;
        FR_ARM:   frame <= FR_WAIT;
        FR_WAIT: begin
          if (!i_srbusy) begin
            if (digit == 3'd5) begin
              frame <= FR_LATCH;
            end else begin
              digit <= digit + 3'd1;
              frame <= FR_LOAD;
            end
          end
        end
        FR_LATCH: frame <= FR_IDLE;
        default:  frame <= FR_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_display_sequencer.sv
// Self-checking bench for display_sequencer: directed steps plus a randomized phase,
// compared every cycle against a timing-arithmetic reference model.
module tb_display_sequencer;

  localparam int TD = 8;
  localparam int RD = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic set_btn = 1'b0, up_btn = 1'b0, down_btn = 1'b0, srbusy = 1'b0;
  logic srload, latch, cnt_en, adj_min, adj_hr, adj_dir, blank;
  logic [2:0] muxsel;

  int checks = 0;
  int errors = 0;

  display_sequencer #(.TICK_DIV(TD), .REFRESH_DIV(RD)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_set(set_btn), .i_up(up_btn), .i_down(down_btn),
    .i_srbusy(srbusy), .o_srload(srload), .o_muxsel(muxsel), .o_latch(latch),
    .o_cnt_en(cnt_en), .o_adj_min(adj_min), .o_adj_hr(adj_hr), .o_adj_dir(adj_dir),
    .o_blank(blank)
  );

  always #5 clk = ~clk;

  // Reference model: edges counted since reset release; ticks fall every TD edges after the
  // last prescaler reload, frame starts every RD edges. Modes: 0 run, 1 set hours, 2 set minutes.
  // Frame stage: 0 idle, 1 loading, 2 armed, 3 waiting on the shifter, 4 latching.
  int m_edge, m_tick_base, m_run_entry, m_mode, m_stage, m_digit;
  logic m_blink, m_pending, m_held, m_held_hr, m_held_dir;
  logic [2:0] h_set, h_up, h_down;
  logic e_srload, e_latch, e_cnt, e_hr, e_min, e_dir;

  always @(posedge clk or negedge rst_n) begin : model
    logic set_r, up_r, down_r, wrap, fwrap, take;
    int old_mode;
    if (!rst_n) begin
      m_edge = 0; m_tick_base = 0; m_mode = 0; m_stage = 0; m_digit = 0;
      m_blink = 0; m_pending = 0; m_held = 0; m_held_hr = 0; m_held_dir = 0;
      h_set = 0; h_up = 0; h_down = 0;
      e_srload = 0; e_latch = 0; e_cnt = 0; e_hr = 0; e_min = 0; e_dir = 0;
    end else begin
      m_edge++;
      set_r  = h_set[1] & ~h_set[2];
      up_r   = h_up[1] & ~h_up[2];
      down_r = h_down[1] & ~h_down[2];
      h_set  = {h_set[1:0], set_btn};
      h_up   = {h_up[1:0], up_btn};
      h_down = {h_down[1:0], down_btn};
      wrap   = ((m_edge - m_tick_base) % TD) == 0;
      fwrap  = (m_edge % RD) == 0;

      take = (m_stage == 0) && m_pending;
      e_srload = 0; e_latch = 0;
      case (m_stage)
        0: if (m_pending) begin m_digit = 0; m_stage = 1; e_srload = 1; end
        1: m_stage = 2;
        2: m_stage = 3;
        3: if (!srbusy) begin
             if (m_digit == 5) begin m_stage = 4; e_latch = 1; end
             else begin m_digit++; m_stage = 1; e_srload = 1; end
           end
        default: m_stage = 0;
      endcase
      m_pending = take ? 1'b0 : (m_pending | fwrap);

      old_mode = m_mode;
      e_cnt = wrap && (old_mode == 0) && !set_r;
      e_hr = 0; e_min = 0; e_dir = 0;
      if (m_held) begin
        e_hr = m_held_hr; e_min = !m_held_hr; e_dir = m_held_dir; m_held = 0;
      end else if ((old_mode != 0) && (up_r != down_r)) begin
        if (e_srload || e_latch) begin
          m_held = 1; m_held_hr = (old_mode == 1); m_held_dir = up_r;
        end else begin
          e_hr = (old_mode == 1); e_min = (old_mode == 2); e_dir = up_r;
        end
      end
      if (set_r) begin
        m_mode = (m_mode + 1) % 3;
        m_blink = 0;
        if (old_mode == 2) begin m_tick_base = m_edge; m_run_entry = m_edge; end
      end else if (wrap) begin
        m_blink = ~m_blink;
      end
    end
  end

  int busy_len = 3;
  int busy_left = 0;
  bit rand_buttons = 0;
  int first_cnt = -1, first_load = -1, loads_seen = 0, hr_seen = 0, min_seen = 0;

  task automatic checkBit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic checkInt(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    logic exp_blank;
    exp_blank = m_blink && (((m_mode == 1) && (m_digit >= 4)) ||
                            ((m_mode == 2) && ((m_digit == 2) || (m_digit == 3))));
    checkBit("srload", srload, e_srload);
    checkBit("latch", latch, e_latch);
    checkBit("cnt_en", cnt_en, e_cnt);
    checkBit("adj_hr", adj_hr, e_hr);
    checkBit("adj_min", adj_min, e_min);
    checkBit("adj_dir", adj_dir, e_dir);
    checkBit("blank", blank, exp_blank);
    checkInt("muxsel", int'(muxsel), m_digit);
    if (cnt_en && first_cnt < 0) first_cnt = m_edge;
    if (srload && first_load < 0) first_load = m_edge;
    if (srload) loads_seen++;
    if (adj_hr) hr_seen++;
    if (adj_min) min_seen++;
    if (latch) begin
      checkInt("loads_per_frame", loads_seen, 6);
      loads_seen = 0;
    end
  endtask

  // Shift register emulation: busy for busy_len cycles after each load (random when negative).
  task automatic applyStimulus();
    if (rand_buttons) begin
      if ($urandom_range(39) == 0) set_btn = ~set_btn;
      if ($urandom_range(9) == 0)  up_btn = ~up_btn;
      if ($urandom_range(9) == 0)  down_btn = ~down_btn;
    end
    if (e_srload) busy_left = (busy_len < 0) ? int'($urandom_range(12)) : busy_len;
    srbusy = (busy_left > 0);
    if (busy_left > 0) busy_left--;
  endtask

  task automatic runCycles(input int n);
    repeat (n) begin
      @(negedge clk);
      checkOutput();
      applyStimulus();
    end
  endtask

  task automatic press(input int which, input int len);
    if (which == 0) set_btn = 1'b1;
    if (which == 1 || which == 3) up_btn = 1'b1;
    if (which == 2 || which == 3) down_btn = 1'b1;
    runCycles(len);
    set_btn = 1'b0; up_btn = 1'b0; down_btn = 1'b0;
    runCycles(8);
  endtask

  initial begin
    bit found;
    #1 rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput();
    rst_n = 1'b1;

    $display("[TB] idle run after reset");
    runCycles(200);
    checkInt("first_cnt_en_cycle", first_cnt, 8);
    checkInt("first_srload_cycle", first_load, 65);

    $display("[TB] busy for 10 cycles per load");
    busy_len = 10;
    runCycles(300);

    $display("[TB] set hours");
    press(0, 4);
    busy_len = 40;
    runCycles(120);
    hr_seen = 0; min_seen = 0;
    press(1, 3);
    press(2, 3);
    press(3, 3);
    checkInt("adj_hr_count", hr_seen, 2);
    checkInt("adj_min_in_set_hr", min_seen, 0);

    $display("[TB] set minutes");
    press(0, 4);
    hr_seen = 0; min_seen = 0;
    press(1, 3);
    press(2, 3);
    press(3, 3);
    checkInt("adj_min_count", min_seen, 2);
    checkInt("adj_hr_in_set_min", hr_seen, 0);

    $display("[TB] back to run");
    first_cnt = -1;
    press(0, 4);
    runCycles(12);
    checkInt("cnt_en_after_run_entry", first_cnt - m_run_entry, TD);

    $display("[TB] randomized buttons and busy");
    busy_len = -1;
    rand_buttons = 1;
    runCycles(3000);
    rand_buttons = 0;
    set_btn = 1'b0; up_btn = 1'b0; down_btn = 1'b0;
    runCycles(20);

    $display("[TB] reset during digit 3 wait");
    busy_len = 10;
    found = 0;
    for (int i = 0; i < 400 && !found; i++) begin
      runCycles(1);
      if (m_stage == 3 && m_digit == 3) found = 1;
    end
    checkBit("reached_digit3_wait", found, 1'b1);
    #2 rst_n = 1'b0;
    #1 checkOutput();
    busy_left = 0;
    srbusy = 1'b0;
    loads_seen = 0;
    runCycles(3);
    rst_n = 1'b1;
    first_load = -1;
    busy_len = 2;
    runCycles(100);
    checkInt("first_srload_after_reset", first_load, 65);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
